// File: rtl/regfile_wport_arb_pkg.sv
// Shared types and constants for the GPR write-port arbiter.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
// Contents: GPR address width, default data width, zero-register constant,
// the write-request struct, and a zero-register helper.
package regfile_wport_arb_pkg;

  localparam int GPR_AW    = 5;
  localparam int RF_DATA_W = 32;
  localparam int NUM_GPR   = 1 << GPR_AW;

  localparam logic [GPR_AW-1:0] ZERO_REG = '0;

  // One regfile write request; the default-width form of what the
  // deferred-write buffer holds.
  typedef struct packed {
    logic                 we;
    logic [GPR_AW-1:0]    waddr;
    logic [RF_DATA_W-1:0] wdata;
  } wreq_t;

  function automatic logic is_zero_reg(input logic [GPR_AW-1:0] addr);
    return addr == ZERO_REG;
  endfunction

endpackage

// File: rtl/wport_fifo.sv
// Deferred-write buffer: DEPTH-entry FIFO of write requests, head visible combinationally.
// Latency: a pushed entry becomes the head one cycle after its push edge.
// Backpressure: full/empty flags only; the caller must not push when full or pop when empty.
// Ports: clk, resetn (async active-low), push/push_dat, pop, head_dat, full, empty.
module wport_fifo
  import regfile_wport_arb_pkg::*;
#(
  parameter int  DEPTH = 2,
  parameter type T     = wreq_t
) (
  input  logic clk,
  input  logic resetn,
  input  logic push,
  input  T     push_dat,
  input  logic pop,
  output T     head_dat,
  output logic full,
  output logic empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  T              mem_q [DEPTH];
  T              mem_d [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q,  count_d;

  // DEPTH is a power of two, so pointers wrap naturally; a single-entry
  // buffer keeps both pointers pinned at zero.
  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (DEPTH == 1) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      mem_d[wr_ptr_q] = push_dat;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    count_d = count_q + CW'(push) - CW'(pop);
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign head_dat = mem_q[rd_ptr_q];
  assign full     = (count_q == CW'(DEPTH));
  assign empty    = (count_q == '0);

endmodule

// File: rtl/regfile_wport_arb.sv
// GPR write-port arbiter (WB > buffered LU > direct LU) plus long-latency pending scoreboard and ID stall.
// Latency: WB 0 cycles; LU 0 cycles via bypass when port idle and buffer empty, else >=1 cycle in FIFO order.
// Backpressure: WB never stalled; lu_ready low while the buffer is full; stallreq holds ID on RAW/WAW against pending LU writes.
// Optional feature: REGFILE_WPORT_BYPASS_EN enables the direct LU-to-port path.
// Ports: clk/resetn; wb_*; lu_issue/lu_rd; lu_valid/lu_ready/lu_waddr/lu_wdata; rf_*; ren*/raddr*; id_wen/id_waddr; stallreq.
module regfile_wport_arb
  import regfile_wport_arb_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int DATA_W = RF_DATA_W
) (
  input  logic              clk,
  input  logic              resetn,
  input  logic              wb_we,
  input  logic [GPR_AW-1:0] wb_waddr,
  input  logic [DATA_W-1:0] wb_wdata,
  input  logic              lu_issue,
  input  logic [GPR_AW-1:0] lu_rd,
  input  logic              lu_valid,
  input  logic [GPR_AW-1:0] lu_waddr,
  input  logic [DATA_W-1:0] lu_wdata,
  output logic              lu_ready,
  output logic              rf_we,
  output logic [GPR_AW-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic              ren1,
  input  logic [GPR_AW-1:0] raddr1,
  input  logic              ren2,
  input  logic [GPR_AW-1:0] raddr2,
  input  logic              id_wen,
  input  logic [GPR_AW-1:0] id_waddr,
  output logic              stallreq
);

  // Same layout as wreq_t, sized by this instance's DATA_W.
  typedef struct packed {
    logic              we;
    logic [GPR_AW-1:0] waddr;
    logic [DATA_W-1:0] wdata;
  } req_t;

  req_t               push_req, head_req;
  logic               fifo_full, fifo_empty;
  logic               lu_acc, push, pop, lu_src;
  logic [NUM_GPR-1:0] pending_q, pending_d;
`ifdef REGFILE_WPORT_BYPASS_EN
  logic               lu_direct;
`endif

  // Handshake and buffer control. lu_ready looks only at the registered
  // count, so a pop in a full cycle does not open a slot until next cycle.
  always_comb begin
    lu_ready = !fifo_full;
    lu_acc   = lu_valid && !fifo_full;
`ifdef REGFILE_WPORT_BYPASS_EN
    lu_direct = lu_acc && !wb_we && fifo_empty;
    push      = lu_acc && !lu_direct;
`else
    push      = lu_acc;
`endif
    pop            = !wb_we && !fifo_empty;
    push_req.we    = !is_zero_reg(lu_waddr);
    push_req.waddr = lu_waddr;
    push_req.wdata = lu_wdata;
  end

  wport_fifo #(
    .DEPTH (DEPTH),
    .T     (req_t)
  ) u_fifo (
    .clk      (clk),
    .resetn   (resetn),
    .push     (push),
    .push_dat (push_req),
    .pop      (pop),
    .head_dat (head_req),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  // Write-port priority mux; lu_src marks an LU-sourced write so the
  // scoreboard only retires bits for results it was actually waiting on.
  always_comb begin
    rf_we    = 1'b0;
    rf_waddr = wb_waddr;
    rf_wdata = wb_wdata;
    lu_src   = 1'b0;
    if (wb_we) begin
      rf_we = !is_zero_reg(wb_waddr);
    end else if (!fifo_empty) begin
      rf_we    = head_req.we;
      rf_waddr = head_req.waddr;
      rf_wdata = head_req.wdata;
      lu_src   = 1'b1;
`ifdef REGFILE_WPORT_BYPASS_EN
    end else if (lu_direct) begin
      rf_we    = !is_zero_reg(lu_waddr);
      rf_waddr = lu_waddr;
      rf_wdata = lu_wdata;
      lu_src   = 1'b1;
`endif
    end
  end

  // Scoreboard: the set is applied after the clear so a new issue to the
  // register retiring this cycle stays pending.
  always_comb begin
    pending_d = pending_q;
    if (lu_src && rf_we) pending_d[rf_waddr] = 1'b0;
    if (lu_issue && !is_zero_reg(lu_rd)) pending_d[lu_rd] = 1'b1;
    pending_d[ZERO_REG] = 1'b0;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) pending_q <= '0;
    else         pending_q <= pending_d;
  end

  always_comb begin
    stallreq = (ren1   && !is_zero_reg(raddr1)   && pending_q[raddr1])
            || (ren2   && !is_zero_reg(raddr2)   && pending_q[raddr2])
            || (id_wen && !is_zero_reg(id_waddr) && pending_q[id_waddr]);
  end

endmodule

// File: tb/tb_regfile_wport_arb.sv
// Self-checking bench for regfile_wport_arb: scoreboard of LU results plus per-scenario tasks.
// Latency: expectations follow REGFILE_WPORT_BYPASS_EN (0-cycle direct path when defined).
// Backpressure: LU offers are held until lu_ready; WB is driven freely.
module tb_regfile_wport_arb;

  logic        clk = 1'b0;
  logic        resetn;
  logic        wb_we;
  logic [4:0]  wb_waddr;
  logic [31:0] wb_wdata;
  logic        lu_issue;
  logic [4:0]  lu_rd;
  logic        lu_valid;
  logic [4:0]  lu_waddr;
  logic [31:0] lu_wdata;
  logic        lu_ready;
  logic        rf_we;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic        ren1, ren2, id_wen;
  logic [4:0]  raddr1, raddr2, id_waddr;
  logic        stallreq;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [4:0]  a;
    logic [31:0] d;
  } exp_t;
  exp_t lu_exp[$];

  always #5 clk = ~clk;

  regfile_wport_arb #(.DEPTH(2), .DATA_W(32)) dut (
    .clk(clk), .resetn(resetn),
    .wb_we(wb_we), .wb_waddr(wb_waddr), .wb_wdata(wb_wdata),
    .lu_issue(lu_issue), .lu_rd(lu_rd),
    .lu_valid(lu_valid), .lu_waddr(lu_waddr), .lu_wdata(lu_wdata), .lu_ready(lu_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .ren1(ren1), .raddr1(raddr1), .ren2(ren2), .raddr2(raddr2),
    .id_wen(id_wen), .id_waddr(id_waddr), .stallreq(stallreq)
  );

  task automatic idle();
    wb_we = 0; wb_waddr = 0; wb_wdata = 0;
    lu_issue = 0; lu_rd = 0;
    lu_valid = 0; lu_waddr = 0; lu_wdata = 0;
    ren1 = 0; raddr1 = 0; ren2 = 0; raddr2 = 0;
    id_wen = 0; id_waddr = 0;
  endtask

  task automatic adv();
    @(posedge clk);
    #1;
  endtask

  // Sample point (falling edge): record accepted LU results, then check any
  // port write against WB inputs or the head of the LU scoreboard.
  task automatic sample();
    exp_t e;
    @(negedge clk);
    if (resetn) begin
      if (lu_valid && lu_ready === 1'b1 && lu_waddr != 5'd0) begin
        e.a = lu_waddr;
        e.d = lu_wdata;
        lu_exp.push_back(e);
      end
      if (wb_we) begin
        checks++;
        if (wb_waddr == 5'd0) begin
          if (rf_we !== 1'b0) begin
            errors++;
            $display("FAIL sb_wb_r0 rf_we=%b required 0", rf_we);
          end
        end else if (rf_we !== 1'b1 || rf_waddr !== wb_waddr || rf_wdata !== wb_wdata) begin
          errors++;
          $display("FAIL sb_wb got we=%b r%0d %h required we=1 r%0d %h",
                   rf_we, rf_waddr, rf_wdata, wb_waddr, wb_wdata);
        end
      end else if (rf_we === 1'b1) begin
        checks++;
        if (lu_exp.size() == 0) begin
          errors++;
          $display("FAIL sb_lu_unexpected got r%0d %h required no write", rf_waddr, rf_wdata);
        end else begin
          e = lu_exp.pop_front();
          if (rf_waddr !== e.a || rf_wdata !== e.d) begin
            errors++;
            $display("FAIL sb_lu_order got r%0d %h required r%0d %h", rf_waddr, rf_wdata, e.a, e.d);
          end
        end
      end
    end
  endtask

  task automatic test_reset();
    idle();
    resetn = 0;
    ren1 = 1; raddr1 = 5; id_wen = 1; id_waddr = 7;
    adv(); adv();
    @(negedge clk);
    checks++;
    if (lu_ready !== 1'b1 || stallreq !== 1'b0 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_state got rdy=%b stall=%b we=%b required 1/0/0", lu_ready, stallreq, rf_we);
    end
    adv();
    resetn = 1;
    idle();
    sample();
    checks++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0) begin
      errors++;
      $display("FAIL reset_release got rdy=%b we=%b required 1/0", lu_ready, rf_we);
    end
    adv();
  endtask

  task automatic test_bypass();
    idle();
    lu_issue = 1; lu_rd = 5;
    sample(); adv();
    lu_issue = 0; ren1 = 1; raddr1 = 5;
    sample();
    checks++;
    if (stallreq !== 1'b1) begin
      errors++; $display("FAIL bypass_pending stall=%b required 1", stallreq);
    end
    adv();
    lu_valid = 1; lu_waddr = 5; lu_wdata = 32'hDEADBEEF;
    sample();
`ifdef REGFILE_WPORT_BYPASS_EN
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL bypass_direct got we=%b r%0d %h stall=%b required 1 r5 deadbeef 1",
               rf_we, rf_waddr, rf_wdata, stallreq);
    end
    adv();
    lu_valid = 0;
    sample();
`else
    checks++;
    if (rf_we !== 1'b0) begin
      errors++; $display("FAIL nobypass_defer got we=%b required 0", rf_we);
    end
    adv();
    lu_valid = 0;
    sample();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd5 || rf_wdata !== 32'hDEADBEEF || stallreq !== 1'b1) begin
      errors++;
      $display("FAIL nobypass_retire got we=%b r%0d %h stall=%b required 1 r5 deadbeef 1",
               rf_we, rf_waddr, rf_wdata, stallreq);
    end
    adv();
    sample();
`endif
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL bypass_clear stall=%b required 0", stallreq);
    end
    adv();
    idle();
  endtask

  task automatic test_contention();
    logic [4:0]  lu_a [3];
    logic [31:0] lu_d [3];
    lu_a[0] = 7;  lu_d[0] = 32'h7777;
    lu_a[1] = 8;  lu_d[1] = 32'h8888;
    lu_a[2] = 12; lu_d[2] = 32'hCCCC;
    idle();
    for (int i = 0; i < 3; i++) begin
      lu_issue = 1; lu_rd = lu_a[i];
      sample(); adv();
    end
    lu_issue = 0;
    for (int c = 1; c <= 3; c++) begin
      wb_we = 1; wb_waddr = 3; wb_wdata = 32'h3000 + c;
      lu_valid = 1; lu_waddr = lu_a[c-1]; lu_wdata = lu_d[c-1];
      sample();
      checks++;
      if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || lu_ready !== (c < 3)) begin
        errors++;
        $display("FAIL contention_wb c%0d got we=%b r%0d rdy=%b required 1 r3 rdy=%b",
                 c, rf_we, rf_waddr, lu_ready, (c < 3));
      end
      adv();
    end
    wb_we = 0;
    sample();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd7 || lu_ready !== 1'b0) begin
      errors++;
      $display("FAIL contention_c4 got we=%b r%0d rdy=%b required 1 r7 rdy=0", rf_we, rf_waddr, lu_ready);
    end
    adv();
    sample();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd8 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL contention_c5 got we=%b r%0d rdy=%b required 1 r8 rdy=1", rf_we, rf_waddr, lu_ready);
    end
    adv();
    lu_valid = 0;
    sample();
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd12) begin
      errors++; $display("FAIL contention_c6 got we=%b r%0d required 1 r12", rf_we, rf_waddr);
    end
    adv();
    ren1 = 1; raddr1 = 8; ren2 = 1; raddr2 = 12; id_wen = 1; id_waddr = 7;
    sample();
    checks++;
    if (rf_we !== 1'b0 || stallreq !== 1'b0 || lu_exp.size() != 0) begin
      errors++;
      $display("FAIL contention_drain got we=%b stall=%b left=%0d required 0/0/0",
               rf_we, stallreq, lu_exp.size());
    end
    adv();
    idle();
  endtask

  task automatic test_stall();
    int cyc;
    logic [2:0] want;
    idle();
    lu_issue = 1; lu_rd = 9;
    sample(); adv();
    lu_issue = 0;
    // {ren1,raddr1=9?} style probes: RAW port1, WAW, r0 read, RAW port2, other reg, ren gated.
    for (int p = 0; p < 6; p++) begin
      idle();
      case (p)
        0: begin ren1 = 1; raddr1 = 9; want = 1; end
        1: begin id_wen = 1; id_waddr = 9; want = 1; end
        2: begin ren1 = 1; raddr1 = 0; want = 0; end
        3: begin ren2 = 1; raddr2 = 9; want = 1; end
        4: begin ren1 = 1; raddr1 = 10; want = 0; end
        default: begin ren1 = 0; raddr1 = 9; want = 0; end
      endcase
      sample();
      checks++;
      if (stallreq !== want[0]) begin
        errors++; $display("FAIL stall_probe%0d stall=%b required %b", p, stallreq, want[0]);
      end
      adv();
    end
    idle();
    ren1 = 1; raddr1 = 9;
    lu_valid = 1; lu_waddr = 9; lu_wdata = 32'h99;
    cyc = 0;
    sample();
    while (stallreq === 1'b1 && cyc < 5) begin
      adv();
      lu_valid = 0;
      cyc++;
      sample();
    end
    checks++;
`ifdef REGFILE_WPORT_BYPASS_EN
    if (cyc != 1) begin
`else
    if (cyc != 2) begin
`endif
      errors++; $display("FAIL stall_release cycles=%0d stall=%b", cyc, stallreq);
    end
    adv();
    idle();
  endtask

  task automatic test_same_cycle();
    int cyc;
    idle();
    lu_issue = 1; lu_rd = 4;
    sample(); adv();
    lu_issue = 0;
    lu_valid = 1; lu_waddr = 4; lu_wdata = 32'h44;
`ifdef REGFILE_WPORT_BYPASS_EN
    lu_issue = 1; lu_rd = 4;
    sample();
`else
    sample(); adv();
    lu_valid = 0; lu_issue = 1; lu_rd = 4;
    sample();
`endif
    checks++;
    if (rf_we !== 1'b1 || rf_waddr !== 5'd4) begin
      errors++; $display("FAIL same_cycle_retire got we=%b r%0d required 1 r4", rf_we, rf_waddr);
    end
    adv();
    idle();
    ren1 = 1; raddr1 = 4;
    sample();
    checks++;
    if (stallreq !== 1'b1) begin
      errors++; $display("FAIL same_cycle_set_wins stall=%b required 1", stallreq);
    end
    adv();
    lu_valid = 1; lu_waddr = 4; lu_wdata = 32'h45;
    cyc = 0;
    sample();
    while (stallreq === 1'b1 && cyc < 5) begin
      adv(); lu_valid = 0; cyc++; sample();
    end
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL same_cycle_cleanup stall=%b required 0", stallreq);
    end
    adv();
    idle();
  endtask

  task automatic test_r0();
    int bad;
    idle();
    lu_issue = 1; lu_rd = 0;
    lu_valid = 1; lu_waddr = 0; lu_wdata = 32'h1;
    ren1 = 1; raddr1 = 0; id_wen = 1; id_waddr = 0;
    sample();
    checks++;
    if (rf_we !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL r0_offer got we=%b stall=%b required 0/0", rf_we, stallreq);
    end
    adv();
    lu_issue = 0; lu_valid = 0;
    sample();
    checks++;
    if (rf_we !== 1'b0 || stallreq !== 1'b0) begin
      errors++; $display("FAIL r0_drain got we=%b stall=%b required 0/0", rf_we, stallreq);
    end
    adv();
    wb_we = 1; wb_waddr = 0; wb_wdata = 32'h5;
    sample();
    adv();
    idle();
    sample();
    bad = 0;
    ren1 = 1;
    for (int r = 1; r < 32; r++) begin
      raddr1 = 5'(r);
      #0.1;
      if (stallreq !== 1'b0) bad++;
    end
    checks++;
    if (bad != 0) begin
      errors++; $display("FAIL r0_pending_clean pending_regs=%0d required 0", bad);
    end
    adv();
    idle();
  endtask

  task automatic test_back_to_back();
    int k;
    idle();
    for (int i = 0; i < 4; i++) begin
      lu_issue = 1; lu_rd = 5'(13 + i);
      sample(); adv();
    end
    lu_issue = 0;
    k = 0;
    for (int cyc = 0; cyc < 20 && k < 4; cyc++) begin
      lu_valid = 1; lu_waddr = 5'(13 + k); lu_wdata = 32'hB000 + k;
      sample();
      if (lu_ready === 1'b1) k++;
      adv();
    end
    lu_valid = 0;
    for (int cyc = 0; cyc < 8 && lu_exp.size() != 0; cyc++) begin
      sample(); adv();
    end
    checks++;
    if (k != 4 || lu_exp.size() != 0) begin
      errors++;
      $display("FAIL back_to_back accepted=%0d left=%0d required 4/0", k, lu_exp.size());
    end
    ren1 = 1; raddr1 = 13; ren2 = 1; raddr2 = 16;
    sample();
    checks++;
    if (stallreq !== 1'b0) begin
      errors++; $display("FAIL back_to_back_clear stall=%b required 0", stallreq);
    end
    adv();
    idle();
  endtask

  task automatic test_reset_mid();
    idle();
    lu_issue = 1; lu_rd = 10;
    sample(); adv();
    lu_rd = 11;
    sample(); adv();
    lu_issue = 0;
    wb_we = 1; wb_waddr = 20; wb_wdata = 32'h2020;
    lu_valid = 1; lu_waddr = 10; lu_wdata = 32'hA;
    sample(); adv();
    lu_waddr = 11; lu_wdata = 32'hB;
    sample(); adv();
    lu_valid = 0;
    ren1 = 1; raddr1 = 10;
    sample();
    checks++;
    if (lu_ready !== 1'b0 || stallreq !== 1'b1) begin
      errors++; $display("FAIL mid_full got rdy=%b stall=%b required 0/1", lu_ready, stallreq);
    end
    #1;
    resetn = 0;
    wb_we = 0;
    #1;
    checks++;
    if (lu_ready !== 1'b1 || rf_we !== 1'b0 || stallreq !== 1'b0) begin
      errors++;
      $display("FAIL mid_reset got rdy=%b we=%b stall=%b required 1/0/0", lu_ready, rf_we, stallreq);
    end
    lu_exp.delete();
    adv();
    resetn = 1;
    raddr1 = 11;
    sample();
    checks++;
    if (rf_we !== 1'b0 || stallreq !== 1'b0 || lu_ready !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_after got we=%b stall=%b rdy=%b required 0/0/1", rf_we, stallreq, lu_ready);
    end
    adv();
    idle();
  endtask

  initial begin
    idle();
    resetn = 0;
    test_reset();
    test_bypass();
    test_contention();
    test_stall();
    test_same_cycle();
    test_r0();
    test_back_to_back();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
